par_link_tx: RTL and testbench

//  Host-side transmitter for the XSOC parallel-port link: the far end of the on-chip
//  par_d input / par_s status port. Buffers bytes in a small FIFO and sends each as two

---
 rtl/par_link_tx.sv | 162 ++++++++++++++++
 tb/tb_par_link_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/par_link_tx.sv
// Parallel-port link transmitter: queues bytes and sends each one as two nibbles,
// low nibble first, with a toggle strobe, a toggle acknowledge and an ack timeout.
module par_link_tx #(
    parameter int SETUP   = 2,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8,
    parameter int AW      = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [7:0]   i_din,
    input  logic         i_din_valid,
    output logic         o_din_ready,
    output logic [4:0]   o_par_d,
    input  logic [6:3]   i_par_s,
    output logic [2:0]   o_status,
    output logic         o_busy,
    output logic         o_timeout_err,
    input  logic         i_err_clr
);

    localparam int DEPTH = 1 << AW;
    localparam int SW    = $clog2(SETUP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_ACK,
        S_HALT
    } state_t;

    state_t         r_state;
    logic [6:3]     r_sync1;
    logic [6:3]     r_sync2;
    logic [7:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [3:0]     r_hold_hi;
    logic           r_nib;
    logic [SW-1:0]  r_scnt;
    logic [TW-1:0]  r_tcnt;
    logic [4:0]     r_par_d;
    logic           r_timeout_err;

    logic           w_ack_s;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_flush;
    logic [7:0]     w_head;

    assign w_ack_s      = r_sync2[3];
    assign w_empty      = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    // Ready comes from the registered count only, so a pop never frees a slot the same cycle.
    assign o_din_ready  = (r_count < (AW+1)'(DEPTH)) && (r_state != S_HALT);
    assign w_push       = i_din_valid && o_din_ready;
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_flush      = (r_state == S_HALT) && i_err_clr;

    assign o_par_d       = r_par_d;
    assign o_status      = r_sync2[6:4];
    assign o_timeout_err = r_timeout_err;
    assign o_busy        = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_par_s;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_par_d       <= '0;
            r_hold_hi     <= '0;
            r_nib         <= 1'b0;
            r_scnt        <= '0;
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_hold_hi    <= w_head[7:4];
                        r_par_d[3:0] <= w_head[3:0];
                        r_nib        <= 1'b0;
                        r_scnt       <= SW'(SETUP);
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_scnt == SW'(1)) begin
                        r_par_d[4] <= ~r_par_d[4];
                        r_tcnt     <= TW'(TIMEOUT);
                        r_state    <= S_WAIT_ACK;
                    end else begin
                        r_scnt <= r_scnt - 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    // A matching ack wins over an expiring timeout in the same cycle.
                    if (w_ack_s == r_par_d[4]) begin
                        if (!r_nib) begin
                            r_par_d[3:0] <= r_hold_hi;
                            r_nib        <= 1'b1;
                            r_scnt       <= SW'(SETUP);
                            r_state      <= S_SETUP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_tcnt == '0) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_HALT;
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
                S_HALT: begin
                    if (i_err_clr) begin
                        // Realign the strobe with the far end's last ack so the next toggle is seen.
                        r_par_d[4] <= w_ack_s;
                        r_nib      <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_par_link_tx.sv
// Bench for par_link_tx: nibble scoreboard fed at push time, strobe-toggle monitor,
// plus directed timing checks around setup, ack echo, timeout, clear and reset.
module tb_par_link_tx;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_din;
    logic       i_din_valid;
    logic       o_din_ready;
    logic [4:0] o_par_d;
    logic [6:3] par_s;
    logic [2:0] o_status;
    logic       o_busy;
    logic       o_timeout_err;
    logic       i_err_clr;

    logic       ack_echo;
    logic       ack_hold;
    logic [2:0] st_drv;
    logic       mute;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    assign par_s = {st_drv, ack_echo ? o_par_d[4] : ack_hold};

    par_link_tx dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_din         (i_din),
        .i_din_valid   (i_din_valid),
        .o_din_ready   (o_din_ready),
        .o_par_d       (o_par_d),
        .i_par_s       (par_s),
        .o_status      (o_status),
        .o_busy        (o_busy),
        .o_timeout_err (o_timeout_err),
        .i_err_clr     (i_err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe toggle presents a nibble; compare against the scoreboard.
    initial begin
        logic prev;
        logic [3:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!mute && (o_par_d[4] != prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL nibble: got %0h expected none (queue empty) at %0t", o_par_d[3:0], $time);
                end else begin
                    e = exp_q.pop_front();
                    check("nibble", o_par_d[3:0], e);
                end
            end
            prev = o_par_d[4];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] b, input int nexp);
        logic acc;
        acc = 1'b0;
        i_din = b;
        i_din_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = o_din_ready;
            tick();
        end
        i_din_valid = 1'b0;
        check("push_accept", acc, 1);
        if (acc && nexp >= 1) exp_q.push_back(b[3:0]);
        if (acc && nexp >= 2) exp_q.push_back(b[7:4]);
    endtask

    task automatic wait_toggle(input logic old);
        logic nv;
        nv = !old;
        for (int k = 0; k < 400 && o_par_d[4] == old; k++) tick();
        check("strobe_toggle", o_par_d[4], nv);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && o_busy; k++) tick();
        check("busy_done", o_busy, 0);
    endtask

    initial begin
        logic [4:0] frozen;
        logic       hold;
        i_rst = 1'b1;
        i_din = '0;
        i_din_valid = 1'b0;
        i_err_clr = 1'b0;
        ack_echo = 1'b1;
        ack_hold = 1'b0;
        st_drv = 3'b000;
        mute = 1'b0;

        // 1: reset state
        tick();
        i_rst = 1'b0;
        check("rst_par_d", o_par_d, 5'h00);
        check("rst_din_ready", o_din_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_timeout_err", o_timeout_err, 0);
        check("rst_status", o_status, 0);

        // 2: loopback echo of 8'hA5 with cycle-exact timing
        push_byte(8'hA5, 2);
        check("a5_busy_after_push", o_busy, 1);
        tick();
        check("a5_lo_nibble", o_par_d[3:0], 4'h5);
        check("a5_strobe_before", o_par_d[4], 0);
        tick();
        check("a5_strobe_setup", o_par_d[4], 0);
        tick();
        check("a5_strobe_rise", o_par_d[4], 1);
        tick(); tick();
        check("a5_lo_held", o_par_d[3:0], 4'h5);
        tick();
        check("a5_hi_nibble", o_par_d[3:0], 4'hA);
        tick();
        check("a5_strobe_hold", o_par_d[4], 1);
        tick();
        check("a5_strobe_fall", o_par_d[4], 0);
        tick(); tick();
        check("a5_busy_before_done", o_busy, 1);
        tick();
        check("a5_busy_done", o_busy, 0);

        // 3: ack held, five bytes back-to-back fill the FIFO behind the one in flight
        ack_hold = o_par_d[4];
        ack_echo = 1'b0;
        push_byte(8'h11, 2);
        push_byte(8'h22, 2);
        push_byte(8'h33, 2);
        push_byte(8'h44, 2);
        push_byte(8'h55, 2);
        check("fill_din_ready", o_din_ready, 0);
        tick(); tick();
        check("fill_din_ready_held", o_din_ready, 0);
        ack_echo = 1'b1;
        wait_idle();
        check("fill_din_ready_back", o_din_ready, 1);

        // 4: no ack -> timeout after exactly TIMEOUT+1 clocks, halt, clear, resume
        hold = o_par_d[4];
        ack_hold = hold;
        ack_echo = 1'b0;
        push_byte(8'h7E, 1);
        push_byte(8'h12, 0);
        push_byte(8'h34, 0);
        wait_toggle(hold);
        for (int k = 0; k < 255; k++) tick();
        check("to_not_early", o_timeout_err, 0);
        tick();
        check("to_set", o_timeout_err, 1);
        check("to_din_ready", o_din_ready, 0);
        check("to_busy", o_busy, 1);
        frozen = o_par_d;
        for (int k = 0; k < 5; k++) tick();
        check("to_par_d_frozen", o_par_d, frozen);
        check("to_sticky", o_timeout_err, 1);
        mute = 1'b1;
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("clr_timeout_err", o_timeout_err, 0);
        check("clr_strobe_realign", o_par_d[4], hold);
        check("clr_fifo_flushed", o_busy, 0);
        check("clr_din_ready", o_din_ready, 1);
        @(negedge clk);
        #1;
        mute = 1'b0;
        ack_echo = 1'b1;
        push_byte(8'h96, 2);
        wait_idle();

        // 5: reset during the high-nibble ack wait, then a clean byte
        push_byte(8'hC3, 2);
        wait_toggle(o_par_d[4]);
        wait_toggle(o_par_d[4]);
        @(negedge clk);
        #1;
        i_rst = 1'b1;
        mute = 1'b1;
        tick();
        check("midrst_par_d", o_par_d, 5'h00);
        check("midrst_busy", o_busy, 0);
        check("midrst_din_ready", o_din_ready, 1);
        i_rst = 1'b0;
        @(negedge clk);
        #1;
        mute = 1'b0;
        push_byte(8'h3C, 2);
        wait_idle();

        // 6: status sync latency, and an ack landing exactly when tcnt reaches 0
        st_drv = 3'b101;
        tick();
        check("status_lag1", o_status, 3'b000);
        tick();
        check("status_synced", o_status, 3'b101);
        hold = o_par_d[4];
        ack_hold = hold;
        ack_echo = 1'b0;
        push_byte(8'h5A, 2);
        wait_toggle(hold);
        for (int k = 0; k < 253; k++) tick();
        ack_hold = o_par_d[4];
        tick(); tick(); tick();
        check("edge_ack_no_err", o_timeout_err, 0);
        check("edge_ack_hi_nibble", o_par_d[3:0], 4'h5);
        ack_echo = 1'b1;
        wait_idle();
        check("edge_ack_no_err_end", o_timeout_err, 0);

        tick(); tick();
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
